toggle_event_decoder: RTL and testbench

- Receiving end of a toggle-encoded event link. Upstream, a T flip-flop inverts its output once per event; this block turns those level changes back into events.
- It synchronises the toggle line and detects each level change.
- It emits a one-cycle pulse per event and queues events in a pending counter, drained through a valid/ready handshake.
- It sits on the consumer side of status/interrupt event links between blocks.

---
 rtl/toggle_event_decoder.sv | 85 ++++++++
 tb/tb_toggle_event_decoder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_decoder.sv
// Receiver for a toggle-encoded event link: synchronises the toggle line, turns each
// level change into a one-cycle pulse and queues events in a saturating pending counter.
module toggle_event_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tgl_in,
  input  logic             en,
  output logic             evt_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   evt_pulse_q, evt_pulse_d;
  logic [CNT_W-1:0]       pending_q, pending_d;
  logic                   ovf_q, ovf_d;

  logic det;
  logic acc;
  logic pop;
  logic sat;

  // Saturating up/down step; a simultaneous push and pop cancel out.
  function automatic logic [CNT_W-1:0] next_pending(input logic [CNT_W-1:0] cur,
                                                    input logic             inc,
                                                    input logic             dec);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec) begin
      if (cur != CNT_MAX) nxt = cur + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cur != '0) nxt = cur - CNT_W'(1);
    end
    return nxt;
  endfunction

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], tgl_in};
    // prev tracks the synchronised level even while disabled, so re-enabling is clean
    prev_d      = sync_q[SYNC_STAGES-1];
    det         = sync_q[SYNC_STAGES-1] ^ prev_q;
    acc         = det && en;
    pop         = evt_valid && evt_ready;
    sat         = acc && !pop && (pending_q == CNT_MAX);
    evt_pulse_d = acc;
    pending_d   = next_pending(pending_q, acc, pop);
    ovf_d       = ovf_q;
    if (sat) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      prev_q      <= 1'b0;
      evt_pulse_q <= 1'b0;
      pending_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      evt_pulse_q <= evt_pulse_d;
      pending_q   <= pending_d;
      ovf_q       <= ovf_d;
    end
  end

  assign evt_pulse = evt_pulse_q;
  assign pending   = pending_q;
  assign evt_valid = (pending_q != '0);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Bench for toggle_event_decoder: directed scenarios plus randomized traffic checked
// against an event-history reference model.
module tb_toggle_event_decoder;

  localparam int S   = 2;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          tgl_in;
  logic          en;
  logic          evt_pulse;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] pending;
  logic          ovf;
  logic          ovf_clr;

  logic [CW+2:0] act;
  assign act = {evt_pulse, evt_valid, ovf, pending};

  int vectors;
  int miscompares;

  // Reference model: tgl_in samples, newest first; an event is accepted when the
  // samples S and S+1 edges back differ and en is high at the current edge.
  bit tq[$];
  int m_pend;
  bit m_ovf;
  bit m_pulse;

  toggle_event_decoder #(.SYNC_STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .tgl_in(tgl_in), .en(en),
    .evt_pulse(evt_pulse), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .pending(pending), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [CW+2:0] exp_vec();
    return {m_pulse, (m_pend != 0), m_ovf, CW'(m_pend)};
  endfunction

  task automatic model_reset();
    tq = {};
    for (int i = 0; i < S + 2; i++) tq.push_back(1'b0);
    m_pend  = 0;
    m_ovf   = 1'b0;
    m_pulse = 1'b0;
  endtask

  // Called at a falling edge with inputs settled; advances model and DUT one cycle.
  task automatic step();
    bit det, acc, pop, sat;
    tq.push_front(tgl_in);
    void'(tq.pop_back());
    det = tq[S] ^ tq[S+1];
    acc = det && en;
    pop = (m_pend != 0) && evt_ready;
    sat = acc && !pop && (m_pend == MAX);
    if (sat) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (acc && !pop && !sat) m_pend++;
    else if (pop && !acc) m_pend--;
    m_pulse = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    tgl_in    = 1'b0;
    en        = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    tgl_in    = 1'b0;
    en        = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (act !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %b exp %b", act, {(CW+3){1'b0}});
    end
    reset = 1'b1;
    step();
    vectors++;
    if (act !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_release: got %b exp %b", act, exp_vec());
    end
  endtask

  task automatic test_latency();
    tgl_in = 1'b1;
    step();
    step();
    vectors++;
    if (evt_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_early: got %b exp 0", evt_pulse);
    end
    step();
    vectors++;
    if ({evt_pulse, evt_valid, pending} !== {1'b1, 1'b1, CW'(1)}) begin
      miscompares++;
      $display("FAIL lat_event: got pulse=%b valid=%b pending=%0d exp 1 1 1",
               evt_pulse, evt_valid, pending);
    end
    step();
    vectors++;
    if (evt_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_one_cycle: got %b exp 0", evt_pulse);
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    vectors++;
    if ({evt_valid, pending} !== {1'b0, CW'(0)}) begin
      miscompares++;
      $display("FAIL lat_pop: got valid=%b pending=%0d exp 0 0", evt_valid, pending);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, run, max_run;
    pulses = 0; run = 0; max_run = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 6) tgl_in = ~tgl_in;
      step();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b_cycle %0d: got %b exp %b", i, act, exp_vec());
      end
      if (evt_pulse) begin
        pulses++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    vectors++;
    if (pulses != 6 || max_run != 6 || pending !== CW'(6) || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_totals: got pulses=%0d run=%0d pending=%0d ovf=%b exp 6 6 6 0",
               pulses, max_run, pending, ovf);
    end
  endtask

  task automatic test_overflow();
    int pulses, pulses_at_ovf;
    do_reset();
    pulses = 0; pulses_at_ovf = -1;
    for (int i = 0; i < 21; i++) begin
      if (i < 17) tgl_in = ~tgl_in;
      step();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL ovf_cycle %0d: got %b exp %b", i, act, exp_vec());
      end
      if (evt_pulse) pulses++;
      if (ovf && pulses_at_ovf < 0) pulses_at_ovf = pulses;
    end
    vectors++;
    if (pulses != 17 || pulses_at_ovf != 16 || pending !== CW'(MAX) || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_totals: got pulses=%0d ovf_at=%0d pending=%0d ovf=%b exp 17 16 15 1",
               pulses, pulses_at_ovf, pending, ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vectors++;
    if (ovf !== 1'b0 || pending !== CW'(MAX)) begin
      miscompares++;
      $display("FAIL ovf_clear: got ovf=%b pending=%0d exp 0 15", ovf, pending);
    end
    tgl_in = ~tgl_in;
    step();
    step();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    vectors++;
    if (ovf !== 1'b1 || evt_pulse !== 1'b1 || pending !== CW'(MAX)) begin
      miscompares++;
      $display("FAIL ovf_clr_collide: got ovf=%b pulse=%b pending=%0d exp 1 1 15",
               ovf, evt_pulse, pending);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tgl_in = ~tgl_in;
      step();
      step();
    end
    repeat (3) step();
    vectors++;
    if (pending !== CW'(3)) begin
      miscompares++;
      $display("FAIL simul_fill: got %0d exp 3", pending);
    end
    evt_ready = 1'b1;
    tgl_in    = ~tgl_in;
    for (int i = 0; i < 7; i++) begin
      step();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL simul_cycle %0d: got %b exp %b", i, act, exp_vec());
      end
      if (i == 2) begin
        vectors++;
        if (evt_pulse !== 1'b1 || pending !== CW'(1)) begin
          miscompares++;
          $display("FAIL simul_accept: got pulse=%b pending=%0d exp 1 1", evt_pulse, pending);
        end
      end
    end
    evt_ready = 1'b0;
    vectors++;
    if (pending !== CW'(0) || evt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_drain: got pending=%0d valid=%b exp 0 0", pending, evt_valid);
    end
  endtask

  task automatic test_enable();
    int pulses;
    do_reset();
    pulses = 0;
    en = 1'b0;
    tgl_in = 1'b1; step(); step();
    tgl_in = 1'b0; step(); step();
    tgl_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 6) en = 1'b1;
      step();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL en_cycle %0d: got %b exp %b", i, act, exp_vec());
      end
      if (evt_pulse) pulses++;
    end
    vectors++;
    if (pulses != 0 || pending !== CW'(0)) begin
      miscompares++;
      $display("FAIL en_discard: got pulses=%0d pending=%0d exp 0 0", pulses, pending);
    end
    tgl_in = 1'b0;
    repeat (5) begin
      step();
      if (evt_pulse) pulses++;
    end
    vectors++;
    if (pulses != 1 || pending !== CW'(1)) begin
      miscompares++;
      $display("FAIL en_resume: got pulses=%0d pending=%0d exp 1 1", pulses, pending);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2, 0) == 0) tgl_in = ~tgl_in;
      en        = ($urandom_range(7, 0) != 0);
      evt_ready = ($urandom_range(3, 0) == 0);
      ovf_clr   = ($urandom_range(15, 0) == 0);
      step();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL rand_cycle %0d: got %b exp %b", i, act, exp_vec());
      end
    end
    en = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) tgl_in = ~tgl_in;
      step();
    end
    evt_ready = 1'b1;
    repeat (10) step();
    evt_ready = 1'b0;
    vectors++;
    if (pending !== CW'(5) || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_setup: got pending=%0d ovf=%b exp 5 1", pending, ovf);
    end
    tgl_in = ~tgl_in;
    @(posedge clk);
    #2;
    reset  = 1'b0;
    tgl_in = 1'b0;
    #1;
    vectors++;
    if (act !== '0) begin
      miscompares++;
      $display("FAIL arst_immediate: got %b exp %b", act, {(CW+3){1'b0}});
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if (act !== exp_vec()) begin
        miscompares++;
        $display("FAIL arst_cycle %0d: got %b exp %b", i, act, exp_vec());
      end
      if (evt_pulse) pulses++;
    end
    vectors++;
    if (pulses != 0 || pending !== CW'(0)) begin
      miscompares++;
      $display("FAIL arst_quiet: got pulses=%0d pending=%0d exp 0 0", pulses, pending);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    tgl_in      = 1'b0;
    en          = 1'b1;
    evt_ready   = 1'b0;
    ovf_clr     = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_latency();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_enable();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
